// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the registered control decoder.
// Holds the RV32 opcode constants, the encodings of the multi-bit control
// fields and the packed control word carried through the output FIFO.
package ctrl_pkg;

    // Major opcodes recognised by the decoder (instr[6:0]).
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    // funct7 value marking an M-extension operation on the R-type opcode.
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    // Immediate format selector.
    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_e;

    // Source of the value written back to the register file.
    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    // Coarse ALU operation class; the ALU decoder refines ALU_FUNCT.
    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_BRANCH = 2'b01,
        ALU_FUNCT  = 2'b10
    } alu_op_e;

    // Complete control word for one instruction.
    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        cache_wen;
        logic        alu_src;
        logic        alu_a_pc;
        imm_src_e    imm_src;
        result_src_e result_src;
        alu_op_e     alu_op;
        logic        branch;
        logic        jump;
        logic        jalr;
        logic        muldiv;
        logic        illegal;
    } ctrl_word_t;

endpackage

// File: rtl/ctrl_decode_pipe_instr_decode.sv
// instr_decode: purely combinational main decoder, 32-bit instruction in,
// ctrl_word_t out. Build option RV32M_EN: when defined, R-type with
// funct7 = 0000001 decodes as an M-extension op and divides/remainders raise
// div_start_o; when undefined that encoding is reported as illegal.
module instr_decode
    import ctrl_pkg::*;
(
    input  logic [31:0] instr_i,
    output ctrl_word_t  word_o
`ifdef RV32M_EN
    ,
    output logic        div_start_o
`endif
);

    logic [6:0] opcode;
    logic [6:0] funct7;

    assign opcode = instr_i[6:0];
    assign funct7 = instr_i[31:25];

    // Register and immediate fields are decoded further down the pipe.
    logic unused_fields;
    assign unused_fields = ^instr_i[24:7];

    // Map opcode/funct fields to the control word.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        word_o = '0;
`ifdef RV32M_EN
        div_start_o = 1'b0;
`endif
        case (opcode)
            OPC_LOAD: begin
                word_o.reg_write  = 1'b1;
                word_o.imm_src    = IMM_I;
                word_o.alu_src    = 1'b1;
                word_o.result_src = RES_MEM;
                word_o.cache_wen  = 1'b1;
            end
            OPC_OP: begin
                if (funct7 == F7_MULDIV) begin
`ifdef RV32M_EN
                    word_o.reg_write = 1'b1;
                    word_o.alu_op    = ALU_FUNCT;
                    word_o.muldiv    = 1'b1;
                    // funct3[2] set selects DIV/DIVU/REM/REMU.
                    div_start_o      = instr_i[14];
`else
                    word_o.illegal   = 1'b1;
`endif
                end else begin
                    word_o.reg_write = 1'b1;
                    word_o.alu_op    = ALU_FUNCT;
                end
            end
            OPC_STORE: begin
                word_o.mem_write = 1'b1;
                word_o.imm_src   = IMM_S;
                word_o.alu_src   = 1'b1;
            end
            OPC_OP_IMM: begin
                word_o.reg_write = 1'b1;
                word_o.imm_src   = IMM_I;
                word_o.alu_src   = 1'b1;
                word_o.alu_op    = ALU_FUNCT;
            end
            OPC_BRANCH: begin
                word_o.branch  = 1'b1;
                word_o.imm_src = IMM_B;
                word_o.alu_op  = ALU_BRANCH;
            end
            OPC_JAL: begin
                word_o.reg_write  = 1'b1;
                word_o.jump       = 1'b1;
                word_o.imm_src    = IMM_J;
                word_o.result_src = RES_PC4;
            end
            OPC_JALR: begin
                word_o.reg_write  = 1'b1;
                word_o.jalr       = 1'b1;
                word_o.imm_src    = IMM_I;
                word_o.alu_src    = 1'b1;
                word_o.result_src = RES_PC4;
            end
            OPC_AUIPC: begin
                word_o.reg_write  = 1'b1;
                word_o.imm_src    = IMM_U;
                word_o.alu_a_pc   = 1'b1;
                word_o.alu_src    = 1'b1;
                word_o.result_src = RES_ALU;
            end
            OPC_LUI: begin
                word_o.reg_write = 1'b1;
                word_o.imm_src   = IMM_U;
                word_o.alu_src   = 1'b1;
                word_o.alu_op    = ALU_FUNCT;
            end
            default: begin
                word_o.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ctrl_decode_pipe.sv
// ctrl_decode_pipe: registered main decoder. Decodes the offered instruction,
// queues the control word in a BUF_DEPTH-entry FIFO (valid/ready on both
// sides) and presents the FIFO head. Outputs are all-zero while empty.
// Build option RV32M_EN: adds the M-extension decode and a divide hold
// counter that blocks input for DIV_CYCLES-1 cycles after a divide is taken.
// BUF_DEPTH must be a power of two >= 2; DIV_CYCLES must be >= 2.
module ctrl_decode_pipe
    import ctrl_pkg::*;
#(
    parameter int BUF_DEPTH  = 2,
    parameter int DIV_CYCLES = 34,
    parameter int IMM_SRC_W  = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 instr_valid_i,
    output logic                 instr_ready_o,
    input  logic [31:0]          instr_i,
    output logic                 ctrl_valid_o,
    input  logic                 ctrl_ready_i,
    output logic                 reg_write_o,
    output logic                 mem_write_o,
    output logic                 cache_wen_o,
    output logic                 alu_src_o,
    output logic                 alu_a_pc_o,
    output logic [IMM_SRC_W-1:0] imm_src_o,
    output logic [1:0]           result_src_o,
    output logic [1:0]           alu_op_o,
    output logic                 branch_o,
    output logic                 jump_o,
    output logic                 jalr_o,
    output logic                 muldiv_o,
    output logic                 illegal_o,
    output logic                 busy_o
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    ctrl_word_t        dec_word;
    ctrl_word_t        head;
    ctrl_word_t        mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              full;
    logic              push;
    logic              pop;
    logic              hold_active;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
`ifdef RV32M_EN
    logic div_start;
`endif

    instr_decode u_decode (
        .instr_i     (instr_i),
        .word_o      (dec_word)
`ifdef RV32M_EN
        ,
        .div_start_o (div_start)
`endif
    );

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    // Ready looks only at registered state plus flush, so a full FIFO does
    // not take a new word even in a cycle where the head is being popped;
    // this keeps ctrl_ready_i off the instr_ready_o path.
    assign full          = (count_q == CNT_W'(BUF_DEPTH));
    assign ctrl_valid_o  = (count_q != '0);
    assign instr_ready_o = !full && !hold_active && !flush_i;
    assign push          = instr_valid_i && instr_ready_o;
    assign pop           = ctrl_valid_o && ctrl_ready_i;

    // ------------------------------------------------------------------
    // FIFO storage
    // ------------------------------------------------------------------
    // Write the decoded word at the tail on an accepted transfer.
    // NOTE: the storage array has no reset; count_q alone says which
    // entries are live, and empty outputs are forced to zero below.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= dec_word;
        end
    end

    // Pointer and occupancy bookkeeping; flush overrides push and pop.
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Divide hold
    // ------------------------------------------------------------------
`ifdef RV32M_EN
    localparam int HOLD_W = $clog2(DIV_CYCLES);

    logic [HOLD_W-1:0] hold_q;

    // Load on an accepted divide, then count down to zero; flush clears it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_q <= '0;
        end else if (flush_i) begin
            hold_q <= '0;
        end else if (push && div_start) begin
            hold_q <= HOLD_W'(DIV_CYCLES - 1);
        end else if (hold_q != '0) begin
            hold_q <= hold_q - HOLD_W'(1);
        end
    end

    assign hold_active = (hold_q != '0);
`else
    assign hold_active = 1'b0;
`endif

    assign busy_o = hold_active;

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Present the FIFO head, or an all-zero word when nothing is queued.
    always_comb begin
        head = '0;
        if (ctrl_valid_o) begin
            head = mem_q[rd_ptr_q];
        end
    end

    assign reg_write_o  = head.reg_write;
    assign mem_write_o  = head.mem_write;
    assign cache_wen_o  = head.cache_wen;
    assign alu_src_o    = head.alu_src;
    assign alu_a_pc_o   = head.alu_a_pc;
    assign imm_src_o    = IMM_SRC_W'(head.imm_src);
    assign result_src_o = head.result_src;
    assign alu_op_o     = head.alu_op;
    assign branch_o     = head.branch;
    assign jump_o       = head.jump;
    assign jalr_o       = head.jalr;
    assign muldiv_o     = head.muldiv;
    assign illegal_o    = head.illegal;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// tb_ctrl_decode_pipe: directed bench for ctrl_decode_pipe. Expected control
// words are hand-encoded constants in the order
// {rw, mw, cache_wen, alu_src, alu_a_pc, imm[2:0], res[1:0], alu_op[1:0],
//  branch, jump, jalr, muldiv, illegal}.
module tb_ctrl_decode_pipe;

    localparam int BUF_DEPTH  = 2;
    localparam int DIV_CYCLES = 34;
    localparam int IMM_SRC_W  = 3;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic                 flush_i;
    logic                 instr_valid_i;
    logic                 instr_ready_o;
    logic [31:0]          instr_i;
    logic                 ctrl_valid_o;
    logic                 ctrl_ready_i;
    logic                 reg_write_o;
    logic                 mem_write_o;
    logic                 cache_wen_o;
    logic                 alu_src_o;
    logic                 alu_a_pc_o;
    logic [IMM_SRC_W-1:0] imm_src_o;
    logic [1:0]           result_src_o;
    logic [1:0]           alu_op_o;
    logic                 branch_o;
    logic                 jump_o;
    logic                 jalr_o;
    logic                 muldiv_o;
    logic                 illegal_o;
    logic                 busy_o;

    int errors = 0;
    int checks = 0;

    // Instructions used as stimulus.
    localparam logic [31:0] I_LW    = 32'h0000A083;
    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_SW    = 32'h0020A023;
    localparam logic [31:0] I_ADDI  = 32'h00108093;
    localparam logic [31:0] I_BEQ   = 32'h00208063;
    localparam logic [31:0] I_JAL   = 32'h008000EF;
    localparam logic [31:0] I_JALR  = 32'h000080E7;
    localparam logic [31:0] I_AUIPC = 32'h00000097;
    localparam logic [31:0] I_LUI   = 32'h000000B7;
    localparam logic [31:0] I_ILL   = 32'h0000007F;
    localparam logic [31:0] I_DIVU  = 32'h0220D0B3;

    // Hand-encoded expected control words.
    localparam logic [16:0] EXP_NONE  = 17'b0;
    localparam logic [16:0] EXP_LW    = {5'b10110, 3'b000, 2'b01, 2'b00, 5'b00000};
    localparam logic [16:0] EXP_ADD   = {5'b10000, 3'b000, 2'b00, 2'b10, 5'b00000};
    localparam logic [16:0] EXP_SW    = {5'b01010, 3'b001, 2'b00, 2'b00, 5'b00000};
    localparam logic [16:0] EXP_ADDI  = {5'b10010, 3'b000, 2'b00, 2'b10, 5'b00000};
    localparam logic [16:0] EXP_BEQ   = {5'b00000, 3'b010, 2'b00, 2'b01, 5'b10000};
    localparam logic [16:0] EXP_JAL   = {5'b10000, 3'b011, 2'b10, 2'b00, 5'b01000};
    localparam logic [16:0] EXP_JALR  = {5'b10010, 3'b000, 2'b10, 2'b00, 5'b00100};
    localparam logic [16:0] EXP_AUIPC = {5'b10011, 3'b100, 2'b00, 2'b00, 5'b00000};
    localparam logic [16:0] EXP_LUI   = {5'b10010, 3'b100, 2'b00, 2'b10, 5'b00000};
    localparam logic [16:0] EXP_ILL   = {5'b00000, 3'b000, 2'b00, 2'b00, 5'b00001};
    localparam logic [16:0] EXP_DIVU  = {5'b10000, 3'b000, 2'b00, 2'b10, 5'b00010};

    logic [31:0] dec_instr [10] = '{I_LW, I_ADD, I_SW, I_ADDI, I_BEQ,
                                    I_JAL, I_JALR, I_AUIPC, I_LUI, I_ILL};
    logic [16:0] dec_exp   [10] = '{EXP_LW, EXP_ADD, EXP_SW, EXP_ADDI, EXP_BEQ,
                                    EXP_JAL, EXP_JALR, EXP_AUIPC, EXP_LUI, EXP_ILL};
    string       dec_name  [10] = '{"lw", "add", "sw", "addi", "beq",
                                    "jal", "jalr", "auipc", "lui", "illegal"};

    ctrl_decode_pipe #(
        .BUF_DEPTH  (BUF_DEPTH),
        .DIV_CYCLES (DIV_CYCLES),
        .IMM_SRC_W  (IMM_SRC_W)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .flush_i       (flush_i),
        .instr_valid_i (instr_valid_i),
        .instr_ready_o (instr_ready_o),
        .instr_i       (instr_i),
        .ctrl_valid_o  (ctrl_valid_o),
        .ctrl_ready_i  (ctrl_ready_i),
        .reg_write_o   (reg_write_o),
        .mem_write_o   (mem_write_o),
        .cache_wen_o   (cache_wen_o),
        .alu_src_o     (alu_src_o),
        .alu_a_pc_o    (alu_a_pc_o),
        .imm_src_o     (imm_src_o),
        .result_src_o  (result_src_o),
        .alu_op_o      (alu_op_o),
        .branch_o      (branch_o),
        .jump_o        (jump_o),
        .jalr_o        (jalr_o),
        .muldiv_o      (muldiv_o),
        .illegal_o     (illegal_o),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Gather the DUT control outputs in the same order as the EXP_* words.
    function automatic logic [16:0] obs();
        return {reg_write_o, mem_write_o, cache_wen_o, alu_src_o, alu_a_pc_o,
                imm_src_o, result_src_o, alu_op_o,
                branch_o, jump_o, jalr_o, muldiv_o, illegal_o};
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni        = 1'b0;
        flush_i       = 1'b0;
        instr_valid_i = 1'b0;
        instr_i       = 32'h0;
        ctrl_ready_i  = 1'b0;
        #2;
        checks++;
        if (ctrl_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b want 0", ctrl_valid_o);
        end
        checks++;
        if (obs() !== EXP_NONE) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want %b", obs(), EXP_NONE);
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b want 0", busy_o);
        end
        repeat (2) tick();
        rst_ni = 1'b1;
        tick();
    endtask

    // One instruction at a time through an always-ready consumer.
    task automatic test_decode();
        ctrl_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (instr_ready_o !== 1'b1) begin
                errors++;
                $display("FAIL dec_ready_%s: got %b want 1", dec_name[i], instr_ready_o);
            end
            instr_valid_i = 1'b1;
            instr_i       = dec_instr[i];
            tick();
            instr_valid_i = 1'b0;
            checks++;
            if (ctrl_valid_o !== 1'b1) begin
                errors++;
                $display("FAIL dec_valid_%s: got %b want 1", dec_name[i], ctrl_valid_o);
            end
            checks++;
            if (obs() !== dec_exp[i]) begin
                errors++;
                $display("FAIL dec_word_%s: got %b want %b", dec_name[i], obs(), dec_exp[i]);
            end
            tick();
            checks++;
            if ({ctrl_valid_o, obs()} !== {1'b0, EXP_NONE}) begin
                errors++;
                $display("FAIL dec_empty_%s: got %b want %b", dec_name[i],
                         {ctrl_valid_o, obs()}, {1'b0, EXP_NONE});
            end
        end
        ctrl_ready_i = 1'b0;
    endtask

    // JAL then JALR queued back to back while the consumer stalls.
    task automatic test_back_to_back();
        ctrl_ready_i  = 1'b0;
        instr_valid_i = 1'b1;
        instr_i       = I_JAL;
        tick();
        instr_i       = I_JALR;
        tick();
        instr_valid_i = 1'b0;
        checks++;
        if (obs() !== EXP_JAL) begin
            errors++;
            $display("FAIL b2b_jal: got %b want %b", obs(), EXP_JAL);
        end
        checks++;
        if (instr_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_full_ready: got %b want 0", instr_ready_o);
        end
        ctrl_ready_i = 1'b1;
        tick();
        checks++;
        if (obs() !== EXP_JALR) begin
            errors++;
            $display("FAIL b2b_jalr: got %b want %b", obs(), EXP_JALR);
        end
        tick();
        checks++;
        if (ctrl_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: got %b want 0", ctrl_valid_o);
        end
        ctrl_ready_i = 1'b0;
    endtask

    // Full FIFO stalls the third word, then pop followed by push+pop.
    task automatic test_full_stall();
        ctrl_ready_i  = 1'b0;
        instr_valid_i = 1'b1;
        instr_i       = I_ADDI;
        tick();
        instr_i       = I_SW;
        tick();
        instr_i       = I_LUI;
        checks++;
        if (instr_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL full_ready: got %b want 0", instr_ready_o);
        end
        repeat (2) tick();
        checks++;
        if (obs() !== EXP_ADDI) begin
            errors++;
            $display("FAIL full_head_stable: got %b want %b", obs(), EXP_ADDI);
        end
        ctrl_ready_i = 1'b1;
        #1;
        checks++;
        if (instr_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL full_ready_during_pop: got %b want 0", instr_ready_o);
        end
        tick();
        checks++;
        if ({instr_ready_o, obs()} !== {1'b1, EXP_SW}) begin
            errors++;
            $display("FAIL full_after_pop: got %b want %b", {instr_ready_o, obs()}, {1'b1, EXP_SW});
        end
        tick();
        instr_valid_i = 1'b0;
        checks++;
        if ({ctrl_valid_o, obs()} !== {1'b1, EXP_LUI}) begin
            errors++;
            $display("FAIL full_push_pop: got %b want %b", {ctrl_valid_o, obs()}, {1'b1, EXP_LUI});
        end
        tick();
        checks++;
        if (ctrl_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL full_drain: got %b want 0", ctrl_valid_o);
        end
        ctrl_ready_i = 1'b0;
    endtask

    // Flush with one word queued and a valid input in the same cycle.
    task automatic test_flush();
        ctrl_ready_i  = 1'b0;
        instr_valid_i = 1'b1;
        instr_i       = I_ADD;
        tick();
        instr_i = I_LUI;
        flush_i = 1'b1;
        #1;
        checks++;
        if (instr_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: got %b want 0", instr_ready_o);
        end
        tick();
        flush_i       = 1'b0;
        instr_valid_i = 1'b0;
        checks++;
        if ({ctrl_valid_o, obs()} !== {1'b0, EXP_NONE}) begin
            errors++;
            $display("FAIL flush_empty: got %b want %b", {ctrl_valid_o, obs()}, {1'b0, EXP_NONE});
        end
        tick();
        checks++;
        if (ctrl_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_input_lost: got %b want 0", ctrl_valid_o);
        end
    endtask

    // DIVU decode and, when the M extension is built in, the hold window.
    task automatic test_muldiv();
        int low_cycles;
        ctrl_ready_i  = 1'b1;
        instr_valid_i = 1'b1;
        instr_i       = I_DIVU;
        tick();
        instr_valid_i = 1'b0;
`ifdef RV32M_EN
        checks++;
        if (obs() !== EXP_DIVU) begin
            errors++;
            $display("FAIL div_word: got %b want %b", obs(), EXP_DIVU);
        end
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL div_busy: got %b want 1", busy_o);
        end
        low_cycles = 0;
        while (instr_ready_o !== 1'b1 && low_cycles < 200) begin
            low_cycles++;
            tick();
        end
        checks++;
        if (low_cycles != DIV_CYCLES - 1) begin
            errors++;
            $display("FAIL div_hold_len: got %0d want %0d", low_cycles, DIV_CYCLES - 1);
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL div_busy_end: got %b want 0", busy_o);
        end
        instr_valid_i = 1'b1;
        tick();
        instr_valid_i = 1'b0;
        repeat (5) tick();
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL div_busy_mid: got %b want 1", busy_o);
        end
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({busy_o, instr_ready_o} !== 2'b01) begin
            errors++;
            $display("FAIL div_reset_async: got %b want 01", {busy_o, instr_ready_o});
        end
        tick();
        rst_ni = 1'b1;
        tick();
`else
        low_cycles = 0;
        checks++;
        if (obs() !== EXP_ILL) begin
            errors++;
            $display("FAIL div_illegal: got %b want %b", obs(), EXP_ILL);
        end
        checks++;
        if ({busy_o, instr_ready_o} !== 2'b01) begin
            errors++;
            $display("FAIL div_no_hold: got %b want 01 (cycles %0d)", {busy_o, instr_ready_o}, low_cycles);
        end
        tick();
`endif
        ctrl_ready_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_back_to_back();
        test_full_stall();
        test_flush();
        test_muldiv();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
